fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction fetch controller on the consumer side of the program counter. It reads the PC address and fetches the word from instruction memory over a req/ack + rvalid protocol. It drives the PC's count and load controls and buffers fetched instructions in a 2-entry queue toward decode. Branch/jump redirects from execute reload the PC and flush the in-flight fetch and the queue.

Parameters:
N, `INST_DEPTH, instruction address width (matches pc)
W, `INST_WIDTH, instruction word width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  fetch enable; 0 stops new requests, in-flight fetch still completes
pc_addr  in  N  current PC address (from pc.addr_out)
pc_count  out  1  increment PC (to pc.count)
pc_load  out  1  load PC (to pc.load)
pc_addr_in  out  N  redirect target (to pc.addr_in)
redir_valid  in  1  branch/jump taken, single-cycle pulse
redir_addr  in  N  branch/jump target
mem_req  out  1  instruction memory request
mem_addr  out  N  request address
mem_ack  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid (one per accepted request, >=1 cycle after ack)
mem_rdata  in  W  read data
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst_data  out  W  head instruction
inst_addr  out  N  head instruction address

Behaviour:
- Reset: state IDLE; mem_req=0, mem_addr=0; queue empty, so inst_valid=0; inst_data and inst_addr are 0. pc_count and pc_load are 0 while redir_valid=0.
- pc_load = redir_valid and pc_addr_in = redir_addr, both combinational.
- pc_count = mem_req & mem_ack & ~redir_valid, combinational. Redirect has priority over count.
- Occupancy rule: issue only when queue entries + outstanding request < 2.
- States: IDLE, REQ, WAIT, DISCARD.
  - IDLE: if en & ~redir_valid & space, go to REQ and register mem_addr <= pc_addr. mem_req is registered and goes high the next cycle.
  - REQ: mem_req=1, mem_addr held. Without redirect, mem_ack moves the state to WAIT. With redirect and ack in the same cycle, go to DISCARD. With redirect and no ack, deassert mem_req and go to IDLE; withdrawal is allowed only on redirect.
  - WAIT: on mem_rvalid without redirect, push {mem_addr, mem_rdata} into the queue. Then go to REQ, with mem_addr <= pc_addr, if en & space counting the new entry; otherwise go to IDLE. On redirect with no rvalid, go to DISCARD. On redirect with rvalid in the same cycle, drop the data and go to IDLE.
  - DISCARD: mem_req=0. On mem_rvalid, drop the data and go to IDLE. A redirect here keeps the state in DISCARD.
- Redirect flush: queue is emptied the same edge, so inst_valid=0 the next cycle. A pop in the redirect cycle is still a legal handshake.
- The first request after a redirect goes out at the earliest 2 cycles after the redirect edge: PC loads, then IDLE->REQ.
- Queue: 2-entry FIFO, first-word fall-through. A push and a pop in the same cycle are both honoured, including when the queue is full. Pop = inst_valid & inst_ready. Full queue blocks new requests only; an outstanding response is always accepted because of the occupancy rule. Pointers wrap modulo 2.
- en=0 mid-fetch: the current request/response completes and is queued; no new request is issued.
- Reset mid-operation: immediately IDLE with queue empty. A memory response arriving after reset is ignored because the state is IDLE.
- Addresses are never computed here; sequencing is done only through pc_count.

Decomposition:
- defs.v: INST_DEPTH, INST_WIDTH, and state encodings FETCH_IDLE/REQ/WAIT/DISCARD (2-bit localparams).
- Sub-module inst_buf: 2-entry FWFT FIFO of width N+W with flush, push, pop, count[1:0], empty and full signals.
- fetch_ctrl instantiates inst_buf and holds the FSM plus the PC control logic.

Test Plan:
- Reset, en=1, ideal memory (ack same cycle as req, rvalid 1 cycle after ack), inst_ready=1, mem[k]=0xA0+k -> mem_addr sequence 0,1,2; pc_count one pulse per ack; inst_addr/inst_data 0/0xA0, 1/0xA1, 2/0xA2.
- inst_ready=0 -> after 2 entries (addresses 0,1) mem_req stays 0 and PC holds 2. inst_ready=1 for one cycle -> exactly one new request at address 2.
- redir_valid with redir_addr=0x10 while in WAIT -> pc_load=1 and pc_addr_in=0x10 that cycle, pc_count=0. Queue flushes and the late rvalid is dropped. The next mem_addr is 0x10 and the first queued inst_addr is 0x10.
- redir_valid in the same cycle as mem_ack -> pc_count=0, state DISCARD, the response is not queued, and the next request is at the redirect target.
- Push and pop in the same cycle with a full queue -> count stays 2, order preserved, no lost or duplicated address.
- rst asserted during WAIT, then rvalid arrives -> inst_valid=0 and mem_req=0, nothing queued, and fetch restarts at PC=0 after rst deasserts.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and sizes for the instruction fetch controller.
// Address/data widths track the program counter and instruction memory.
package fetch_ctrl_pkg;

    localparam int INST_DEPTH = 16;
    localparam int INST_WIDTH = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_WAIT    = 2'd2,
        FETCH_DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory-side and decode-side handshake bundle for fetch_ctrl.
// master = fetch controller, slave = memory/decode environment.
interface fetch_ctrl_if
    import fetch_ctrl_pkg::*;
#(
    parameter int N = INST_DEPTH,
    parameter int W = INST_WIDTH
);

    logic         mem_req;
    logic [N-1:0] mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [W-1:0] mem_rdata;

    logic         inst_valid;
    logic         inst_ready;
    logic [W-1:0] inst_data;
    logic [N-1:0] inst_addr;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rvalid, mem_rdata,
        output inst_valid, inst_data, inst_addr,
        input  inst_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rvalid, mem_rdata,
        input  inst_valid, inst_data, inst_addr,
        output inst_ready
    );

endinterface

// File: rtl/fetch_ctrl_inst_buf.sv
// Two-entry first-word-fall-through instruction queue with flush.
// Head output reads as zero while the queue is empty.
module fetch_ctrl_inst_buf #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop & ~empty;
    // a full queue still takes a push when the head leaves the same cycle
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: req/ack + rvalid memory fetch, PC
// count/load control, and a 2-entry queue toward decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int N = INST_DEPTH,
    parameter int W = INST_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  pc_addr,
    output logic          pc_count,
    output logic          pc_load,
    output logic [N-1:0]  pc_addr_in,
    input  logic          redir_valid,
    input  logic [N-1:0]  redir_addr,
    fetch_ctrl_if.master  bus
);

    fetch_state_e   state;
    fetch_state_e   state_n;
    logic           req_q;
    logic [N-1:0]   addr_q;
    logic           load_addr;
    logic           push;
    logic           pop;
    logic           empty;
    logic           full;
    logic [1:0]     count;
    logic [2:0]     count_n;
    logic           idle_space;
    logic           wait_space;
    logic [N+W-1:0] head;

    assign pc_load    = redir_valid;
    assign pc_addr_in = redir_addr;
    assign pc_count   = req_q & bus.mem_ack & ~redir_valid;

    assign bus.mem_req  = req_q;
    assign bus.mem_addr = addr_q;

    assign bus.inst_valid = ~empty;
    assign {bus.inst_addr, bus.inst_data} = head;

    assign pop  = ~empty & bus.inst_ready;
    assign push = (state == FETCH_WAIT) & bus.mem_rvalid & ~redir_valid;

    // queue occupancy after this edge; a new request needs it below 2
    assign count_n    = {1'b0, count} + {2'b0, push} - {2'b0, pop};
    assign idle_space = ~full | pop;
    assign wait_space = (count_n < 3'd2);

    always_comb begin
        state_n   = state;
        load_addr = 1'b0;
        unique case (state)
            FETCH_IDLE: begin
                if (en & ~redir_valid & idle_space) begin
                    state_n   = FETCH_REQ;
                    load_addr = 1'b1;
                end
            end
            FETCH_REQ: begin
                if (redir_valid) begin
                    state_n = bus.mem_ack ? FETCH_DISCARD : FETCH_IDLE;
                end else if (bus.mem_ack) begin
                    state_n = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (redir_valid) begin
                    state_n = bus.mem_rvalid ? FETCH_IDLE : FETCH_DISCARD;
                end else if (bus.mem_rvalid) begin
                    if (en & wait_space) begin
                        state_n   = FETCH_REQ;
                        load_addr = 1'b1;
                    end else begin
                        state_n = FETCH_IDLE;
                    end
                end
            end
            FETCH_DISCARD: begin
                if (bus.mem_rvalid) begin
                    state_n = FETCH_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH_IDLE;
            req_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_n;
            req_q <= (state_n == FETCH_REQ);
            if (load_addr) begin
                addr_q <= pc_addr;
            end
        end
    end

    fetch_ctrl_inst_buf #(
        .WIDTH(N + W)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (redir_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({addr_q, bus.mem_rdata}),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

endmodule
